put_in_order_dispatch: RTL and testbench

Round-robin dispatcher that feeds n_inputs parallel variable-latency processing units.
- Accepts one item per cycle from a valid/ready upstream.
- Issues items to units strictly in order 0,1,…,n_inputs-1,0,… and tracks each unit as busy until it completes.
- Unit results return out of order and go into put_in_order (up_vlds/up_data), which restores issue order. This block guarantees the slot-order invariant put_in_order relies on: never more than one outstanding item per unit.

---
 rtl/put_in_order_pkg.sv | 16 +
 rtl/put_in_order_dispatch_popcount.sv | 19 +
 rtl/put_in_order_dispatch.sv | 87 ++++++++
 tb/tb_put_in_order_dispatch.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/put_in_order_pkg.sv
// Shared types and defaults for the put_in_order dispatcher and reorder stage.
// The ptr_t/cnt_t typedefs match the default unit count.
package put_in_order_pkg;

  localparam int unsigned default_width    = 8;
  localparam int unsigned default_n_inputs = 10;

  typedef logic [$clog2(default_n_inputs)-1:0]   ptr_t;
  typedef logic [$clog2(default_n_inputs+1)-1:0] cnt_t;

  // Round-robin successor that wraps at n-1, so non-power-of-2 counts never reach index n.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/put_in_order_dispatch_popcount.sv
// Purely combinational population count of an n-bit vector.
module put_in_order_dispatch_popcount #(
  parameter int unsigned n = 10
) (
  input  logic [n-1:0]             bits_i,
  output logic [$clog2(n+1)-1:0]   count_o
);

  localparam int unsigned cw = $clog2(n + 1);

  // NOTE: count_o is assigned a default before the loop so the block can never infer a latch.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < n; i++) begin
      count_o = count_o + cw'(bits_i[i]);
    end
  end

endmodule

// File: rtl/put_in_order_dispatch.sv
// Round-robin dispatcher that keeps at most one outstanding item per processing unit,
// so results can be put back in issue order downstream.
module put_in_order_dispatch
  import put_in_order_pkg::*;
#(
  parameter int unsigned width    = default_width,
  parameter int unsigned n_inputs = default_n_inputs
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               up_vld,
  output logic                               up_rdy,
  input  logic [width-1:0]                   up_data,
  output logic [n_inputs-1:0]                dispatch_vlds,
  output logic [n_inputs-1:0][width-1:0]     dispatch_data,
  input  logic [n_inputs-1:0]                done_vlds,
  output logic [n_inputs-1:0]                busy,
  output logic [$clog2(n_inputs+1)-1:0]      in_flight,
  output logic                               idle,
  output logic                               err
);

  localparam int unsigned pw = $clog2(n_inputs);
  localparam int unsigned cw = $clog2(n_inputs + 1);

  logic [pw-1:0]                    ptr_q, ptr_d;
  logic [n_inputs-1:0]              busy_q, busy_d;
  logic [cw-1:0]                    in_flight_q, in_flight_d;
  logic [n_inputs-1:0]              dispatch_vlds_q, dispatch_vlds_d;
  logic [n_inputs-1:0][width-1:0]   dispatch_data_q, dispatch_data_d;
  logic                             err_q, err_d;

  logic                             fire;
  logic [n_inputs-1:0]              ptr_onehot;
  logic [cw-1:0]                    done_count;

  // Only completions from busy units retire an item; stray ones only raise err.
  put_in_order_dispatch_popcount #(.n(n_inputs)) u_popcount (
    .bits_i  (done_vlds & busy_q),
    .count_o (done_count)
  );

  // A unit freed this cycle is only visible next cycle: no bypass from done_vlds.
  assign up_rdy = rst & ~busy_q[ptr_q];
  assign fire   = up_vld & up_rdy;

  always_comb begin
    ptr_onehot      = n_inputs'(1) << ptr_q;
    busy_d          = (busy_q & ~done_vlds) | (fire ? ptr_onehot : '0);
    err_d           = err_q | (|(done_vlds & ~busy_q));
    in_flight_d     = in_flight_q + cw'(fire) - done_count;
    ptr_d           = fire ? pw'(next_ptr(32'(ptr_q), n_inputs)) : ptr_q;
    dispatch_vlds_d = fire ? ptr_onehot : '0;
    dispatch_data_d = dispatch_data_q;
    if (fire) begin
      dispatch_data_d[ptr_q] = up_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the per-unit data registers are reset too, because they are visible outputs that must read 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q           <= '0;
      busy_q          <= '0;
      in_flight_q     <= '0;
      dispatch_vlds_q <= '0;
      dispatch_data_q <= '0;
      err_q           <= 1'b0;
    end else begin
      ptr_q           <= ptr_d;
      busy_q          <= busy_d;
      in_flight_q     <= in_flight_d;
      dispatch_vlds_q <= dispatch_vlds_d;
      dispatch_data_q <= dispatch_data_d;
      err_q           <= err_d;
    end
  end

  assign dispatch_vlds = dispatch_vlds_q;
  assign dispatch_data = dispatch_data_q;
  assign busy          = busy_q;
  assign in_flight     = in_flight_q;
  assign idle          = (in_flight_q == '0);
  assign err           = err_q;

endmodule

// File: tb/tb_put_in_order_dispatch.sv
// Directed bench for put_in_order_dispatch with n_inputs=10, width=8.
module tb_put_in_order_dispatch;

  localparam int unsigned W = 8;
  localparam int unsigned N = 10;

  logic              clk;
  logic              rst;
  logic              up_vld;
  logic              up_rdy;
  logic [W-1:0]      up_data;
  logic [N-1:0]      dispatch_vlds;
  logic [N-1:0][W-1:0] dispatch_data;
  logic [N-1:0]      done_vlds;
  logic [N-1:0]      busy;
  logic [3:0]        in_flight;
  logic              idle;
  logic              err;

  int checks = 0;
  int errors = 0;

  put_in_order_dispatch #(.width(W), .n_inputs(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .up_vld        (up_vld),
    .up_rdy        (up_rdy),
    .up_data       (up_data),
    .dispatch_vlds (dispatch_vlds),
    .dispatch_data (dispatch_data),
    .done_vlds     (done_vlds),
    .busy          (busy),
    .in_flight     (in_flight),
    .idle          (idle),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    up_vld    = 1'b0;
    up_data   = '0;
    done_vlds = '0;
    #2;
    check("reset up_rdy", 32'(up_rdy), 32'd0);
    check("reset idle", 32'(idle), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_flight", 32'(in_flight), 32'd0);
    check("reset dispatch_vlds", 32'(dispatch_vlds), 32'd0);
    check("reset dispatch_data0", 32'(dispatch_data[0]), 32'd0);
    check("reset err", 32'(err), 32'd0);
    step();
    step();
    rst = 1'b1;
    #1;

    // Test 1: fill all ten units in order, one per cycle.
    for (int i = 0; i < 10; i++) begin
      check("t1 up_rdy before fire", 32'(up_rdy), 32'd1);
      up_vld  = 1'b1;
      up_data = W'(i);
      step();
      check("t1 dispatch_vlds", 32'(dispatch_vlds), 32'(1) << i);
      check("t1 dispatch_data", 32'(dispatch_data[i]), 32'(i));
      check("t1 in_flight", 32'(in_flight), 32'(i + 1));
    end
    check("t1 up_rdy full", 32'(up_rdy), 32'd0);
    check("t1 busy full", 32'(busy), 32'h3FF);
    check("t1 idle", 32'(idle), 32'd0);
    step();
    check("t1 no fire when full", 32'(dispatch_vlds), 32'd0);
    check("t1 in_flight held", 32'(in_flight), 32'd10);

    // Test 2: freeing unit 3 does not unblock ptr=0; freeing unit 0 does, one cycle later.
    up_vld    = 1'b0;
    done_vlds = 10'h008;
    step();
    done_vlds = '0;
    check("t2 busy after done3", 32'(busy), 32'h3F7);
    check("t2 in_flight after done3", 32'(in_flight), 32'd9);
    check("t2 up_rdy blocked", 32'(up_rdy), 32'd0);
    up_vld    = 1'b1;
    up_data   = 8'h0A;
    done_vlds = 10'h001;
    #1;
    check("t2 no bypass", 32'(up_rdy), 32'd0);
    step();
    done_vlds = '0;
    check("t2 no dispatch on done cycle", 32'(dispatch_vlds), 32'd0);
    check("t2 busy after done0", 32'(busy), 32'h3F6);
    check("t2 in_flight after done0", 32'(in_flight), 32'd8);
    check("t2 up_rdy freed", 32'(up_rdy), 32'd1);
    step();
    check("t2 dispatch unit0", 32'(dispatch_vlds), 32'h001);
    check("t2 dispatch_data0", 32'(dispatch_data[0]), 32'h0A);
    check("t2 in_flight", 32'(in_flight), 32'd9);
    check("t2 busy", 32'(busy), 32'h3F7);
    check("t2 ptr=1 busy blocks", 32'(up_rdy), 32'd0);
    check("t2 err clear", 32'(err), 32'd0);

    // Test 5: retire three units, then reset asynchronously with six in flight.
    up_vld    = 1'b0;
    done_vlds = 10'h0E0;
    step();
    done_vlds = '0;
    check("t5 in_flight six", 32'(in_flight), 32'd6);
    check("t5 busy", 32'(busy), 32'h317);
    #2;
    rst = 1'b0;
    #1;
    check("t5 async busy", 32'(busy), 32'd0);
    check("t5 async in_flight", 32'(in_flight), 32'd0);
    check("t5 async dispatch_vlds", 32'(dispatch_vlds), 32'd0);
    check("t5 async idle", 32'(idle), 32'd1);
    check("t5 async up_rdy", 32'(up_rdy), 32'd0);
    step();
    rst = 1'b1;
    #1;

    // Test 4: fire to idle unit 4 while done_vlds[4] is also set.
    for (int i = 0; i < 4; i++) begin
      up_vld  = 1'b1;
      up_data = W'(8'h10 + i);
      step();
    end
    check("t4 busy pre", 32'(busy), 32'h00F);
    up_data   = 8'h44;
    done_vlds = 10'h010;
    step();
    done_vlds = '0;
    up_vld    = 1'b0;
    check("t4 err set", 32'(err), 32'd1);
    check("t4 busy set wins", 32'(busy), 32'h01F);
    check("t4 in_flight", 32'(in_flight), 32'd5);
    check("t4 dispatch unit4", 32'(dispatch_vlds), 32'h010);
    check("t4 dispatch_data4", 32'(dispatch_data[4]), 32'h44);
    step();
    check("t4 err sticky", 32'(err), 32'd1);
    rst = 1'b0;
    #1;
    check("t4 err reset", 32'(err), 32'd0);
    step();
    rst = 1'b1;
    #1;

    // Test 3: 25 items, each unit completing one cycle after dispatch; ptr wraps twice.
    for (int k = 0; k < 25; k++) begin
      check("t3 up_rdy", 32'(up_rdy), 32'd1);
      up_vld    = 1'b1;
      up_data   = W'(k);
      done_vlds = (k > 0) ? (N'(1) << ((k - 1) % 10)) : '0;
      step();
      check("t3 dispatch_vlds", 32'(dispatch_vlds), 32'(1) << (k % 10));
      check("t3 dispatch_data", 32'(dispatch_data[k % 10]), 32'(k));
      check("t3 in_flight", 32'(in_flight), 32'd1);
    end
    up_vld    = 1'b0;
    done_vlds = N'(1) << 4;
    step();
    done_vlds = '0;
    check("t3 drained in_flight", 32'(in_flight), 32'd0);
    check("t3 idle", 32'(idle), 32'd1);
    check("t3 busy", 32'(busy), 32'd0);
    check("t3 err", 32'(err), 32'd0);
    check("t3 ptr at 5 ready", 32'(up_rdy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
